// File: rtl/sprite_fetch_if.sv
// Pixel-stream bundle between vga_controller, motion logic, sprite RAM and color_mapper.
// The slave modport is the sprite_fetch side. The master modport is the environment that drives it.
interface sprite_fetch_if #(
    parameter int ADDR_W = 19
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank_in;
    logic [9:0]        SprX;
    logic [9:0]        SprY;
    logic              spr_en;
    logic              flip;
    logic [ADDR_W-1:0] read_addr;
    logic [3:0]        ram_data;
    logic [3:0]        pix_idx;
    logic              pix_valid;
    logic              blank_out;

    modport master (
        output DrawX, DrawY, blank_in, SprX, SprY, spr_en, flip, ram_data,
        input  read_addr, pix_idx, pix_valid, blank_out
    );

    modport slave (
        input  DrawX, DrawY, blank_in, SprX, SprY, spr_en, flip, ram_data,
        output read_addr, pix_idx, pix_valid, blank_out
    );
endinterface

// File: rtl/sprite_fetch.sv
// Sprite fetch stage: latches position once per frame and walks sprite RAM with an adder-only address generator.
// 3-cycle latency from DrawX/DrawY to pix_idx/pix_valid/blank_out; free-running pixel stream, no backpressure.
module sprite_fetch #(
    parameter int          SPR_W     = 20,
    parameter int          SPR_H     = 30,
    parameter int          ADDR_W    = 19,
    parameter int          V_LATCH   = 480,
    parameter logic [3:0]  TRANS_IDX = 4'd0
) (
    input logic            Clk,
    input logic            Reset,
    sprite_fetch_if.slave  bus
);
    logic [9:0]        r_sx;
    logic [9:0]        r_sy;
    logic              r_en;
    logic              r_flip;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_read_addr;
    logic              r_hit_s1;
    logic              r_hit_s2;
    logic              r_blank_s1;
    logic              r_blank_s2;
    logic [3:0]        r_pix_idx;
    logic              r_pix_valid;
    logic              r_blank_out;

    logic        w_latch;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_hit;
    logic        w_row_end;
    logic [9:0]  w_dx;
    logic [9:0]  w_col;

    assign w_latch = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(V_LATCH));

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    // Rows at or below the latch line are excluded so vertical-blank hits cannot advance row_base.
    assign w_x     = {1'b0, bus.DrawX};
    assign w_y     = {1'b0, bus.DrawY};
    assign w_x_end = {1'b0, r_sx} + 11'(SPR_W);
    assign w_y_end = {1'b0, r_sy} + 11'(SPR_H);
    assign w_hit   = r_en
                  && (w_x >= {1'b0, r_sx}) && (w_x < w_x_end)
                  && (w_y >= {1'b0, r_sy}) && (w_y < w_y_end)
                  && (bus.DrawY < 10'(V_LATCH));

    assign w_dx      = bus.DrawX - r_sx;
    assign w_col     = r_flip ? (10'(SPR_W - 1) - w_dx) : w_dx;
    assign w_row_end = w_hit && (w_x == (w_x_end - 11'd1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sx       <= '0;
            r_sy       <= '0;
            r_en       <= 1'b0;
            r_flip     <= 1'b0;
            r_row_base <= '0;
        end else if (w_latch) begin
            r_sx       <= bus.SprX;
            r_sy       <= bus.SprY;
            r_en       <= bus.spr_en;
            r_flip     <= bus.flip;
            r_row_base <= '0;
        end else if (w_row_end) begin
            r_row_base <= r_row_base + ADDR_W'(SPR_W);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_read_addr <= '0;
            r_hit_s1    <= 1'b0;
            r_hit_s2    <= 1'b0;
            r_blank_s1  <= 1'b0;
            r_blank_s2  <= 1'b0;
            r_pix_idx   <= '0;
            r_pix_valid <= 1'b0;
            r_blank_out <= 1'b0;
        end else begin
            if (w_hit) begin
                r_read_addr <= r_row_base + ADDR_W'(w_col);
            end
            r_hit_s1    <= w_hit;
            r_blank_s1  <= bus.blank_in;
            r_hit_s2    <= r_hit_s1;
            r_blank_s2  <= r_blank_s1;
            r_pix_idx   <= bus.ram_data;
            r_pix_valid <= r_hit_s2 && (bus.ram_data != TRANS_IDX);
            r_blank_out <= r_blank_s2;
        end
    end

    assign bus.read_addr = r_read_addr;
    assign bus.pix_idx   = r_pix_idx;
    assign bus.pix_valid = r_pix_valid;
    assign bus.blank_out = r_blank_out;
endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: a reference model computes each pixel's address by multiplication,
// the expectation is queued at drive time and compared when the DUT's read_addr (+1) and pixel (+3) emerge.
module tb_sprite_fetch;
    localparam int SPR_W = 20;
    localparam int SPR_H = 30;

    typedef struct {
        logic [18:0] addr;
        logic [3:0]  idx;
        logic        vld;
        logic        blank;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_fetch_if #(.ADDR_W(19)) vif ();

    sprite_fetch u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (vif)
    );

    function automatic logic [3:0] ram_f(input logic [18:0] a);
        logic [18:0] t;
        t = a * 19'd5;
        return t[3:0];
    endfunction

    // Sprite RAM model: one-cycle registered read.
    always @(posedge clk) vif.ram_data <= ram_f(vif.read_addr);

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t addr_q[$];
    exp_t pix_q[$];
    int   m_sx = 0, m_sy = 0, m_addr = 0;
    logic m_en = 1'b0, m_flip = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t x=%0d y=%0d)", tag, got, exp, $time, vif.DrawX, vif.DrawY);
        end
    endtask

    task automatic drive(input int x, input int y);
        exp_t e;
        bit   h;
        int   col;
        @(negedge clk);
        if (addr_q.size() >= 1) begin
            e = addr_q.pop_front();
            check("read_addr", 32'(vif.read_addr), 32'(e.addr));
        end
        if (pix_q.size() >= 3) begin
            e = pix_q.pop_front();
            check("pix_idx", 32'(vif.pix_idx), 32'(e.idx));
            check("pix_valid", 32'(vif.pix_valid), 32'(e.vld));
            check("blank_out", 32'(vif.blank_out), 32'(e.blank));
        end
        vif.DrawX    = 10'(x);
        vif.DrawY    = 10'(y);
        vif.blank_in = (x >= 640) || (y >= 480);
        h = m_en && x >= m_sx && x < m_sx + SPR_W && y >= m_sy && y < m_sy + SPR_H && y < 480;
        if (h) begin
            col    = m_flip ? (SPR_W - 1 - (x - m_sx)) : (x - m_sx);
            m_addr = (y - m_sy) * SPR_W + col;
        end
        e.addr  = 19'(m_addr);
        e.idx   = ram_f(19'(m_addr));
        e.vld   = h && (e.idx != 4'd0);
        e.blank = vif.blank_in;
        addr_q.push_back(e);
        pix_q.push_back(e);
        if (x == 0 && y == 480) begin
            m_sx   = int'(vif.SprX);
            m_sy   = int'(vif.SprY);
            m_en   = vif.spr_en;
            m_flip = vif.flip;
        end
    endtask

    task automatic row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) drive(x, y);
    endtask

    task automatic do_latch(input int sx, input int sy, input logic en, input logic fl);
        vif.SprX   = 10'(sx);
        vif.SprY   = 10'(sy);
        vif.spr_en = en;
        vif.flip   = fl;
        drive(0, 480);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_read_addr"}, 32'(vif.read_addr), 32'd0);
        check({pfx, "_pix_idx"}, 32'(vif.pix_idx), 32'd0);
        check({pfx, "_pix_valid"}, 32'(vif.pix_valid), 32'd0);
        check({pfx, "_blank_out"}, 32'(vif.blank_out), 32'd0);
    endtask

    initial begin
        vif.DrawX = '0; vif.DrawY = '0; vif.blank_in = 1'b1;
        vif.SprX = '0; vif.SprY = '0; vif.spr_en = 1'b0; vif.flip = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Frame 1: unflipped at (100,200); SprX change mid-sprite must not take effect.
        do_latch(100, 200, 1'b1, 1'b0);
        row(199, 96, 123);
        for (int y = 200; y < 230; y++) begin
            if (y == 215) vif.SprX = 10'd300;
            row(y, 96, 123);
        end

        // Frame 2: new X takes effect only after the latch, row_base restarts at 0.
        vif.SprY = 10'd200;
        drive(0, 480);
        row(200, 96, 123);
        for (int y = 200; y < 230; y++) row(y, 298, 321);

        // Frame 3: mirrored.
        do_latch(100, 200, 1'b1, 1'b1);
        for (int y = 200; y < 230; y++) row(y, 98, 121);

        // Frame 4: right and bottom clipping, no wrap onto the next line.
        do_latch(630, 470, 1'b1, 1'b0);
        row(469, 626, 651);
        row(470, 626, 651);
        row(471, 0, 11);
        for (int y = 471; y < 480; y++) row(y, 626, 651);
        drive(0, 480);
        row(480, 626, 651);

        // Frame 5: reset mid-frame, invisible until the next latch.
        do_latch(100, 200, 1'b1, 1'b0);
        for (int y = 200; y < 210; y++) row(y, 96, 123);
        row(210, 96, 105);
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        addr_q.delete();
        pix_q.delete();
        m_en = 1'b0; m_flip = 1'b0; m_sx = 0; m_sy = 0; m_addr = 0;
        @(posedge clk);
        #1 check("midrst_hold_addr", 32'(vif.read_addr), 32'd0);
        rst = 1'b0;
        row(210, 106, 123);
        for (int y = 211; y < 230; y++) row(y, 96, 123);
        drive(0, 480);
        row(200, 96, 123);
        row(201, 96, 123);

        repeat (6) drive(700, 500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
